// File: rtl/alu_muldiv.sv
// alu_muldiv: EX-stage ALU with iterative multiply/divide engine and HI/LO registers
// Ports:
//   clk, reset_n         clock, asynchronous active-low reset
//   start, f, a, b       op issue (accepted only when busy=0), op select, operands
//   y, zero, overflow    registered ALU result, y==0, signed ADD/SUB overflow
//   busy, done           mult/div in progress, one-cycle result-valid pulse
//   hi, lo               HI/LO registers (product halves or remainder/quotient)
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [3:0]       f,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y,
  output logic             zero,
  output logic             overflow,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, MUL, DIV, FIX} state_t;
  state_t state, state_nx;
  logic [CW-1:0] cnt;
  logic [WIDTH-1:0] ma, acc, q, sum, dif, alu_y, diff_w;
  logic [WIDTH:0] add_s, rem_s;
  logic [2*WIDTH-1:0] prod;
  logic neg_lo, neg_hi, is_mul, alu_ov, issue, md_op, sgn, dz, ge;
  assign busy   = state != IDLE;
  assign issue  = start && !busy;
  assign md_op  = f >= 4'd10 && f <= 4'd13;
  assign sgn    = !f[0];
  // Division by zero runs the raw dividend through the divider: quotient becomes all ones, remainder a.
  assign dz     = f[2] && b == '0;
  assign sum    = a + b;
  assign dif    = a - b;
  // acc:q acts as the double-width product register while multiplying, remainder:dividend while dividing.
  assign add_s  = {1'b0, acc} + {1'b0, q[0] ? ma : '0};
  assign rem_s  = {acc, q[WIDTH-1]};
  assign ge     = rem_s >= {1'b0, ma};
  assign diff_w = rem_s[WIDTH-1:0] - ma;
  assign prod   = {acc, q};
  always_comb begin
    alu_y = '0;
    case (f)
      4'd0:  alu_y = a & b;
      4'd1:  alu_y = a | b;
      4'd2:  alu_y = sum;
      4'd3:  alu_y = a ^ b;
      4'd4:  alu_y = a & ~b;
      4'd5:  alu_y = a | ~b;
      4'd6:  alu_y = dif;
      4'd7:  alu_y = {{(WIDTH-1){1'b0}}, $signed(a) < $signed(b)};
      4'd8:  alu_y = {{(WIDTH-1){1'b0}}, a < b};
      4'd9:  alu_y = ~(a | b);
      4'd14: alu_y = hi;
      4'd15: alu_y = lo;
      default: alu_y = '0;
    endcase
    alu_ov = f == 4'd2 ? (a[WIDTH-1] == b[WIDTH-1] && sum[WIDTH-1] != a[WIDTH-1]) :
             f == 4'd6 ? (a[WIDTH-1] != b[WIDTH-1] && dif[WIDTH-1] != a[WIDTH-1]) : 1'b0;
  end
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:     state_nx = issue && md_op ? (f[2] ? DIV : MUL) : IDLE;
      MUL, DIV: state_nx = cnt == '0 ? FIX : state;
      default:  state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      y <= '0;
      zero <= 1'b1;
      overflow <= 1'b0;
      done <= 1'b0;
      hi <= '0;
      lo <= '0;
      cnt <= '0;
      ma <= '0;
      acc <= '0;
      q <= '0;
      neg_lo <= 1'b0;
      neg_hi <= 1'b0;
      is_mul <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (issue) begin
          if (md_op) begin
            overflow <= 1'b0;
            is_mul <= !f[2];
            cnt <= CW'(WIDTH - 1);
            acc <= '0;
            ma <= sgn && b[WIDTH-1] ? -b : b;
            q <= sgn && a[WIDTH-1] && !dz ? -a : a;
            neg_lo <= sgn && !dz && (a[WIDTH-1] ^ b[WIDTH-1]);
            neg_hi <= sgn && !dz && a[WIDTH-1];
          end else begin
            y <= alu_y;
            zero <= alu_y == '0;
            overflow <= alu_ov;
            done <= 1'b1;
          end
        end
        MUL: begin
          acc <= add_s[WIDTH:1];
          q <= {add_s[0], q[WIDTH-1:1]};
          cnt <= cnt - 1'b1;
        end
        DIV: begin
          acc <= ge ? diff_w : rem_s[WIDTH-1:0];
          q <= {q[WIDTH-2:0], ge};
          cnt <= cnt - 1'b1;
        end
        default: begin
          if (is_mul) {hi, lo} <= neg_lo ? -prod : prod;
          else begin
            lo <= neg_lo ? -q : q;
            hi <= neg_hi ? -acc : acc;
          end
          done <= 1'b1;
        end
      endcase
    end
  end
endmodule
